// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states,
// sizing constants and the byte-address decoder.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_e;

  localparam int unsigned WORD_BYTES  = 4;
  localparam int unsigned LATENCY_MAX = 7;
  localparam logic [31:0] ERR_RDATA   = 32'h0;

  typedef struct packed {
    logic [29:0] word;
    logic        misaligned;
    logic        out_of_range;
  } dm_addr_dec_t;

  // Word index is the full byte address minus the lane bits; the caller keeps
  // only the low addr_width bits, so anything above them is an out-of-range access.
  function automatic dm_addr_dec_t dm_decode_addr(input logic [31:0] addr,
                                                  input int unsigned addr_width);
    dm_addr_dec_t dec;
    dec.word         = addr[31:2];
    dec.misaligned   = (addr[1:0] != 2'b00);
    dec.out_of_range = ((addr >> (addr_width + 2)) != 32'd0);
    return dec;
  endfunction

endpackage

// File: rtl/dm_ram_bank.sv
// Word-wide storage with per-byte write enables and a registered read port
// that share one enable. Contents are never reset.
module dm_ram_bank
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    en_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [31:0]             wdata_i,
  input  logic [WORD_BYTES-1:0]   be_i,
  output logic [31:0]             rdata_o
);

  logic [31:0] mem_q [2**ADDR_WIDTH];
  logic [31:0] rdata_q;

  // Read-before-write: a store's read register picks up the old word, which
  // the responder masks off anyway.
  always_ff @(posedge clk) begin
    if (en_i) begin
      rdata_q <= mem_q[addr_i];
      if (we_i) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
          if (be_i[i]) begin
            mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
          end
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder for the CPU load/store port: accepts one request,
// waits LATENCY cycles, commits it, then holds the response until taken.
module dm_responder
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned         CNT_W    = $clog2(LATENCY_MAX + 1);
  localparam logic [CNT_W-1:0]    CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  dm_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;

  logic             rsp_err_q;
  logic             rsp_load_q;

  logic             accept;
  logic             enter_resp;
  logic             cur_we;
  logic [31:0]      cur_addr;
  logic [31:0]      cur_wdata;
  logic [3:0]       cur_be;
  logic             cur_err;
  dm_addr_dec_t     dec;
  logic             unused_word_bits;

  logic             ram_en;
  logic [31:0]      ram_rdata;

  assign accept = req_valid && (state_q == IDLE);

  // With zero latency the commit happens on the accept edge itself, so the
  // live request inputs are used in IDLE and the latched copy afterwards.
  assign cur_we    = (state_q == IDLE) ? req_we    : we_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign cur_be    = (state_q == IDLE) ? req_be    : be_q;

  assign dec              = dm_decode_addr(cur_addr, ADDR_WIDTH);
  assign cur_err          = dec.misaligned || dec.out_of_range;
  assign unused_word_bits = ^dec.word;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_err_q  <= 1'b0;
      rsp_load_q <= 1'b0;
    end else if (enter_resp) begin
      rsp_err_q  <= cur_err;
      rsp_load_q <= !cur_we && !cur_err;
    end
  end

  // Errored requests never touch the bank; reset blocks a commit racing the edge.
  assign ram_en = reset && enter_resp && !cur_err;

  dm_ram_bank #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (cur_we),
    .addr_i  (dec.word[ADDR_WIDTH-1:0]),
    .wdata_i (cur_wdata),
    .be_i    (cur_be),
    .rdata_o (ram_rdata)
  );

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid && rsp_err_q;
  assign rsp_rdata = (rsp_valid && rsp_load_q) ? ram_rdata : ERR_RDATA;

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder for the CPU core's load/store port; the CPU is the initiator, this block services each request.
- One request is accepted at a time, held for a configurable wait time, then answered with a response that is held until the CPU takes it.
- Sits beside the CPU core in the top level. Its fixed, parameterised latency lets the bench exercise the core's stall logic.

Parameters:
- ADDR_WIDTH, 10, word-address bits; memory depth = 2**ADDR_WIDTH 32-bit words.
- LATENCY, 2, wait cycles between request accept and response (legal 0..7).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- req_valid  input  1  CPU presents a request.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  byte enables for stores; bit i enables byte lane i (bits [8i+7:8i]).
- rsp_valid  output  1  response available.
- rsp_ready  input  1  CPU consumes the response.
- rsp_rdata  output  32  load data; 0 for stores and for errors.
- rsp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. Memory contents are not reset and are undefined until written.
- States:
  - IDLE: req_ready=1. A handshake (req_valid & req_ready) latches we/addr/wdata/be. Next state is WAIT if LATENCY>0, otherwise RESP.
  - WAIT: req_ready=0. The counter loads LATENCY-1 on accept and decrements each cycle. The edge on which the counter is 0 moves to RESP.
  - RESP: rsp_valid=1; rsp_rdata and rsp_err held stable. rsp_valid & rsp_ready moves to IDLE.
- Request inputs are ignored after the accept edge.
- Commit point: the edge that enters RESP.
  - Store: writes each enabled byte lane; req_be=0 is a legal no-op.
  - Load: captures the full word into rsp_rdata; req_be is ignored.
- Timing: rsp_valid is first high exactly LATENCY+1 cycles after the handshake cycle. rsp_valid and rsp_ready high in the same cycle complete the response at that edge.
- req_ready returns to 1 in the cycle after the response handshake. There are no back-to-back transactions; minimum period is LATENCY+2 cycles.
- Word index = req_addr[ADDR_WIDTH+1:2].
- Error rules:
  - Misaligned: req_addr[1:0]!=0.
  - Out of range: req_addr[31:ADDR_WIDTH+2]!=0.
  - On either error: rsp_err=1, rsp_rdata=0, no memory write. The transaction still takes the full latency.
- Highest legal word, (2**ADDR_WIDTH)-1, is valid. The next word address errors; addresses do not wrap.
- A store followed by a load to the same word returns the merged stored bytes.
- Reset asserted mid-WAIT or mid-RESP:
  - An uncommitted store is discarded.
  - A store committed before reset remains in memory.
  - Outputs return to reset values immediately.
- req_valid while req_ready=0 is held by the CPU and is accepted on return to IDLE.

Decomposition:
- Package dm_pkg:
  - State enum (IDLE, WAIT, RESP).
  - Constants: WORD_BYTES=4, LATENCY_MAX=7, ERR_RDATA=32'h0.
  - Function decoding address to word index plus the misaligned/out-of-range flags.
- Sub-module dm_ram_bank: 2**ADDR_WIDTH x 32 array, byte-enabled write and registered read on a shared enable. No reset.
- dm_responder holds the FSM, latency counter, request latches and error logic.

Test Plan:
- LATENCY=2: store addr 0x10, data 0xDEADBEEF, be=4'b1111, rsp_ready=1. Then: rsp_valid high 3 cycles after accept with rsp_err=0 and rsp_rdata=0; load 0x10 returns 0xDEADBEEF.
- Partial store: 0x10 data 0x000000AA be=4'b0001, then load 0x10 -> 0xDEADBEAA. Store be=4'b1100 data 0x12340000, then load -> 0x1234BEAA.
- Errors: load addr 0x13 -> rsp_err=1, rdata=0. Store addr 0x1000 (ADDR_WIDTH=10) -> rsp_err=1, and a load of 0x0 is unchanged. Load 0xFFC -> rsp_err=0.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0. Raise rsp_ready -> rsp_valid=0 and req_ready=1 on the following cycle.
- LATENCY=0: load accepted at cycle k -> rsp_valid in cycle k+1. Back-to-back req_valid held high -> accepts every 2 cycles.
- Reset mid-operation: assert reset=0 during WAIT of a store to 0x20 -> outputs immediately at reset values. After release, a load of 0x20 returns its pre-store value, provided 0x20 was written before the aborted store.
